button_event_fifo: RTL and testbench

Debounces the four raw push-button inputs, detects press events, and queues them in a small FIFO that the processor drains through the memory-mapped button read at data address 7. It sits directly upstream of the address-7 read mux: its `data_out` is the word returned on `lw` from address 7. It replaces level polling, so the game loop never misses a short press or double-counts a held one.

---
 rtl/button_pkg.sv | 30 +++
 rtl/button_debounce.sv | 57 +++++
 rtl/button_event_fifo.sv | 132 +++++++++++++
 tb/tb_button_event_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared event codes, data word bit positions and defaults for the button event queue.
package button_pkg;

    localparam int NUM_BUTTONS             = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    localparam int CODE_LSB     = 0;
    localparam int CODE_MSB     = 2;
    localparam int RELEASE_BIT  = 4;
    localparam int OVERFLOW_BIT = 8;

    typedef enum logic [2:0] {
        EV_NONE   = 3'd0,
        EV_RED    = 3'd1,
        EV_BLUE   = 3'd2,
        EV_GREEN  = 3'd3,
        EV_YELLOW = 3'd4
    } event_code_t;

    typedef struct packed {
        logic        rel;
        event_code_t code;
    } fifo_entry_t;

    // Button index 0..3 (red, blue, green, yellow) maps to codes 1..4.
    function automatic event_code_t code_of(input int idx);
        return event_code_t'(3'(idx + 1));
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stable-level debouncer with registered edge pulses.
// BUTTON_RELEASE_EVENT_EN adds the falling-edge output.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_button,
`ifdef BUTTON_RELEASE_EVENT_EN
    output logic fall,
`endif
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_ff;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = (sync_ff[1] != stable) && (cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_ff <= '0;
            stable  <= 1'b0;
            cnt     <= '0;
            rise    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], raw_button};
            rise    <= flip & sync_ff[1];
            if (sync_ff[1] == stable || flip) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (flip) begin
                stable <= sync_ff[1];
            end
        end
    end

`ifdef BUTTON_RELEASE_EVENT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fall <= 1'b0;
        end else begin
            fall <= flip & ~sync_ff[1];
        end
    end
`endif

endmodule

// File: rtl/button_event_fifo.sv
// Debounced button press events queued for the address-7 read; pop on poll falling edge.
// BUTTON_RELEASE_EVENT_EN also queues release events (bit 4 set).
module button_event_fifo
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        red_button,
    input  logic        blue_button,
    input  logic        green_button,
    input  logic        yellow_button,
    input  logic        poll,
    output logic [31:0] data_out
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_BUTTONS-1:0] raw;
    logic [NUM_BUTTONS-1:0] rise;
    logic [NUM_BUTTONS-1:0] press_pend;
    logic [NUM_BUTTONS-1:0] press_grant;
`ifdef BUTTON_RELEASE_EVENT_EN
    logic [NUM_BUTTONS-1:0] fall;
    logic [NUM_BUTTONS-1:0] rel_pend;
    logic [NUM_BUTTONS-1:0] rel_grant;
`endif

    logic        push_req;
    fifo_entry_t push_entry;
    logic [AW:0] wptr, rptr;
    fifo_entry_t mem [FIFO_DEPTH];
    fifo_entry_t head;
    logic        empty, full;
    logic        poll_q, do_pop, do_push;
    logic        overflow;

    assign raw = {yellow_button, green_button, blue_button, red_button};

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clock     (clock),
            .reset     (reset),
            .raw_button(raw[i]),
`ifdef BUTTON_RELEASE_EVENT_EN
            .fall      (fall[i]),
`endif
            .rise      (rise[i])
        );
    end

    // Scan lowest priority first so red, and press over release, win last.
    always_comb begin
        push_req    = 1'b0;
        push_entry  = '0;
        press_grant = '0;
`ifdef BUTTON_RELEASE_EVENT_EN
        rel_grant   = '0;
`endif
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
`ifdef BUTTON_RELEASE_EVENT_EN
            if (rel_pend[i]) begin
                push_req     = 1'b1;
                push_entry   = '{rel: 1'b1, code: code_of(i)};
                press_grant  = '0;
                rel_grant    = '0;
                rel_grant[i] = 1'b1;
            end
`endif
            if (press_pend[i]) begin
                push_req       = 1'b1;
                push_entry     = '{rel: 1'b0, code: code_of(i)};
                press_grant    = '0;
`ifdef BUTTON_RELEASE_EVENT_EN
                rel_grant      = '0;
`endif
                press_grant[i] = 1'b1;
            end
        end
    end

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = poll_q & ~poll & ~empty;
    assign do_push = push_req & (~full | do_pop);
    assign head    = mem[rptr[AW-1:0]];

    // A granted event leaves its pending flag even when dropped on overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            press_pend <= '0;
`ifdef BUTTON_RELEASE_EVENT_EN
            rel_pend   <= '0;
`endif
            wptr       <= '0;
            rptr       <= '0;
            poll_q     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            press_pend <= (press_pend | rise) & ~press_grant;
`ifdef BUTTON_RELEASE_EVENT_EN
            rel_pend   <= (rel_pend | fall) & ~rel_grant;
`endif
            poll_q     <= poll;
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_pop) begin
                overflow <= 1'b0;
            end else if (push_req && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_entry;
    end

    always_comb begin
        data_out = '0;
        if (!empty) begin
            data_out[CODE_MSB:CODE_LSB] = head.code;
            data_out[RELEASE_BIT]       = head.rel;
        end
        data_out[OVERFLOW_BIT] = overflow;
    end

endmodule

// File: tb/tb_button_event_fifo.sv
// Directed bench for button_event_fifo with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
// Expectations follow BUTTON_RELEASE_EVENT_EN when it is defined.
module tb_button_event_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  btn;
    logic        poll;
    logic [31:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    button_event_fifo #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .red_button   (btn[0]),
        .blue_button  (btn[1]),
        .green_button (btn[2]),
        .yellow_button(btn[3]),
        .poll         (poll),
        .data_out     (data_out)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pop_one();
        poll = 1'b1;
        tick(2);
        poll = 1'b0;
        tick(1);
    endtask

    task automatic drain();
        tick(12);
        for (int i = 0; i < 12; i++) begin
            if (data_out == 32'h0) break;
            pop_one();
        end
    endtask

    task automatic pulse(input int idx);
        btn[idx] = 1'b1;
        tick(6);
        btn[idx] = 1'b0;
        tick(9);
    endtask

    logic [31:0] exp_q [5];
    int          fifth;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        btn   = '0;
        poll  = 1'b0;
        tick(2);
        check("reset_state", data_out, 32'h0);
        reset = 1'b1;
        tick(2);

        // Single red press, read and pop
        btn[0] = 1'b1;
        tick(7);
        check("red_early", data_out, 32'h0);
        tick(1);
        check("red_press", data_out, 32'h1);
        poll = 1'b1;
        tick(3);
        check("red_poll_hold", data_out, 32'h1);
        btn[0] = 1'b0;
        poll   = 1'b0;
        tick(1);
        check("red_pop", data_out, 32'h0);
        tick(20);
`ifdef BUTTON_RELEASE_EVENT_EN
        check("red_release", data_out, 32'h11);
`else
        check("red_single", data_out, 32'h0);
`endif
        drain();

        // Glitch shorter than the debounce window
        btn[1] = 1'b1;
        tick(3);
        btn[1] = 1'b0;
        tick(4);
        check("blue_glitch_mid", data_out, 32'h0);
        tick(10);
        check("blue_glitch", data_out, 32'h0);

        // Simultaneous green and yellow
        btn[2] = 1'b1;
        btn[3] = 1'b1;
        tick(8);
        check("gy_first", data_out, 32'h3);
        pop_one();
        check("gy_second", data_out, 32'h4);
        pop_one();
        check("gy_empty", data_out, 32'h0);
        btn = '0;
        drain();

        // Six presses without polling: overflow
        btn[0] = 1'b1; tick(9);
        btn[1] = 1'b1; tick(9);
        btn[2] = 1'b1; tick(9);
        btn[3] = 1'b1; tick(9);
        btn[0] = 1'b0;
        btn[1] = 1'b0;
        tick(9);
        btn[0] = 1'b1;
        btn[1] = 1'b1;
        tick(10);
        check("ovf_set", data_out, 32'h101);
        pop_one();
        check("ovf_clear", data_out, 32'h2);
        pop_one();
        check("ovf_q3", data_out, 32'h3);
        pop_one();
        check("ovf_q4", data_out, 32'h4);
        pop_one();
        check("ovf_empty", data_out, 32'h0);
        btn = '0;
        drain();

        // Full queue, push on the same edge as a pop
`ifdef BUTTON_RELEASE_EVENT_EN
        pulse(0);
        pulse(1);
        fifth = 2;
        exp_q = '{32'h11, 32'h2, 32'h12, 32'h3, 32'h0};
`else
        pulse(0);
        pulse(1);
        pulse(2);
        pulse(3);
        fifth = 0;
        exp_q = '{32'h2, 32'h3, 32'h4, 32'h1, 32'h0};
`endif
        check("full_head", data_out, 32'h1);
        btn[fifth] = 1'b1;
        tick(5);
        poll = 1'b1;
        tick(2);
        poll = 1'b0;
        tick(1);
        check("full_pushpop", data_out, exp_q[0]);
        for (int i = 1; i < 5; i++) begin
            pop_one();
            check($sformatf("full_order%0d", i), data_out, exp_q[i]);
        end
        btn = '0;
        drain();

        // Asynchronous reset mid-debounce with a non-empty queue
        btn[1] = 1'b1;
        tick(9);
        check("rst_pre", data_out, 32'h2);
        btn[1] = 1'b0;
        btn[0] = 1'b1;
        tick(3);
        reset = 1'b0;
        #1;
        check("rst_async", data_out, 32'h0);
        tick(2);
        check("rst_held", data_out, 32'h0);
        reset = 1'b1;
        tick(7);
        check("rst_red_early", data_out, 32'h0);
        tick(1);
        check("rst_red", data_out, 32'h1);
        pop_one();
        check("rst_red_pop", data_out, 32'h0);
        btn[0] = 1'b0;
        tick(9);
`ifdef BUTTON_RELEASE_EVENT_EN
        check("rst_release", data_out, 32'h11);
`else
        check("rst_no_release", data_out, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
